// File: rtl/tff_pkg.sv
// Shared constants and helpers for the T-flip-flop modulo counter.
// Holds the direction encodings, the load clamp and the parameter legality test.
package tff_pkg;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  localparam int unsigned MAX_WIDTH = 16;

  // Load values at or above the modulus saturate to the top count.
  function automatic logic [MAX_WIDTH-1:0] clamp_mod(input logic [MAX_WIDTH-1:0] din,
                                                     input int unsigned mod);
    if (32'(din) < mod) return din;
    return MAX_WIDTH'(mod - 32'd1);
  endfunction

  function automatic bit params_legal(input int unsigned width, input int unsigned mod);
    return (width >= 32'd1) && (width <= MAX_WIDTH) &&
           (mod >= 32'd2) && (mod <= (32'd1 << width));
  endfunction

endpackage

// File: rtl/t_ff_cell.sv
// Single-bit T flip-flop with synchronous active-high reset.
// Reset clears the cell directly, independent of the toggle input.
module t_ff_cell (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= q ^ t;
  end

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-MOD up/down counter built from T cells: next-state logic produces a
// per-bit toggle vector, tc is the combinational terminal decode, wrap a registered pulse.
module tff_mod_counter
  import tff_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned MOD   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap
);

  localparam int unsigned    XW    = WIDTH + 1;
  localparam logic [WIDTH:0] MAX_X = XW'(MOD - 32'd1);

  if (!params_legal(WIDTH, MOD)) begin : g_bad_params
    $error("tff_mod_counter: illegal WIDTH=%0d / MOD=%0d", WIDTH, MOD);
  end

  logic [WIDTH:0]   q_x;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] load_val;
  logic             at_max;
  logic             at_zero;
  logic             step_wrap;

  assign q_x      = {1'b0, q};
  assign at_max   = (q_x == MAX_X);
  assign at_zero  = (q == '0);
  assign load_val = WIDTH'(clamp_mod(MAX_WIDTH'(din), MOD));

  assign tc = en & ~load & ((up_dn == DIR_UP) ? at_max : at_zero);

  // Next-state selection in WIDTH+1 bits; load beats count, hold keeps q.
  always_comb begin
    q_next    = q;
    step_wrap = 1'b0;
    if (load) begin
      q_next = load_val;
    end else if (en) begin
      if (up_dn == DIR_UP) begin
        step_wrap = at_max;
        q_next    = at_max ? '0 : WIDTH'(q_x + XW'(1));
      end else begin
        step_wrap = at_zero;
        q_next    = at_zero ? WIDTH'(MAX_X) : WIDTH'(q_x - XW'(1));
      end
    end
  end

  assign t = q ^ q_next;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    t_ff_cell u_cell (
      .clk (clk),
      .rst (rst),
      .t   (t[i]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) wrap <= 1'b0;
    else     wrap <= step_wrap;
  end

endmodule

// File: tb/tb_tff_mod_counter.sv
// Scoreboard bench for tff_mod_counter: four configurations share one stimulus bus,
// directed vectors carry hand-computed expectations, a random phase uses a behavioural model.
module tb_tff_mod_counter;
  import tff_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up_dn, load;
  logic [4:0] din;

  logic [3:0] q10, q16;
  logic [0:0] q2;
  logic [4:0] q17;
  logic       tc10, tc16, tc2, tc17;
  logic       wr10, wr16, wr2, wr17;

  tff_mod_counter #(.WIDTH(4), .MOD(10)) u10 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .din(din[3:0]),
    .q(q10), .tc(tc10), .wrap(wr10));
  tff_mod_counter #(.WIDTH(4), .MOD(16)) u16 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .din(din[3:0]),
    .q(q16), .tc(tc16), .wrap(wr16));
  tff_mod_counter #(.WIDTH(1), .MOD(2)) u2 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .din(din[0:0]),
    .q(q2), .tc(tc2), .wrap(wr2));
  tff_mod_counter #(.WIDTH(5), .MOD(17)) u17 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .din(din),
    .q(q17), .tc(tc17), .wrap(wr17));

  typedef struct {
    int unsigned cyc;
    int          dut;
    logic [4:0]  q;
    logic        tc;
    logic        wrap;
    bit          chk_t;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops every expectation stamped for the current cycle and compares.
  always @(negedge clk) begin
    exp_t        e;
    logic [4:0]  aq;
    logic        atc, aw;
    int unsigned m;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      case (e.dut)
        0:       begin aq = {1'b0, q10};  atc = tc10; aw = wr10; m = 10; end
        1:       begin aq = {1'b0, q16};  atc = tc16; aw = wr16; m = 16; end
        2:       begin aq = {4'b0, q2};   atc = tc2;  aw = wr2;  m = 2;  end
        default: begin aq = q17;          atc = tc17; aw = wr17; m = 17; end
      endcase
      vectors++;
      if (e.cyc != cyc || aq !== e.q || atc !== e.tc || aw !== e.wrap || 32'(aq) >= m) begin
        miscompares++;
        $display("FAIL %s dut%0d cyc %0d: got q=%0d tc=%b wrap=%b, expected q=%0d tc=%b wrap=%b (cyc %0d)",
                 e.name, e.dut, cyc, aq, atc, aw, e.q, e.tc, e.wrap, e.cyc);
      end
      if (e.chk_t) begin
        vectors++;
        if (u16.t !== 4'b0) begin
          miscompares++;
          $display("FAIL %s_t cyc %0d: got t=%b, expected t=0000", e.name, cyc, u16.t);
        end
      end
    end
  end

  task automatic step(input int dut, input logic r, input logic e, input logic u,
                      input logic l, input logic [4:0] d, input bit chk,
                      input logic [4:0] eq, input logic etc, input logic ew,
                      input bit ct, input string nm);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; en = e; up_dn = u; load = l; din = d;
    if (chk) begin
      x = '{cyc, dut, eq, etc, ew, ct, nm};
      sb.push_back(x);
    end
  endtask

  task automatic rand_phase();
    int unsigned mods[4] = '{10, 16, 2, 17};
    int unsigned wid[4]  = '{4, 4, 1, 5};
    int unsigned mq[4];
    logic        mw[4];
    int unsigned dv;
    logic        r, e, u, l, etc;
    logic [4:0]  d;
    exp_t        x;
    @(posedge clk);
    #1;
    rst = 1'b1; en = 1'b0; load = 1'b0;
    for (int k = 0; k < 4; k++) begin mq[k] = 0; mw[k] = 1'b0; end
    for (int i = 0; i < 10000; i++) begin
      @(posedge clk);
      #1;
      r = ($urandom_range(0, 99) == 0);
      e = 1'($urandom_range(0, 3) != 0);
      u = 1'($urandom);
      l = ($urandom_range(0, 9) == 0);
      d = 5'($urandom);
      rst = r; en = e; up_dn = u; load = l; din = d;
      for (int k = 0; k < 4; k++) begin
        dv  = 32'(d) & ((32'd1 << wid[k]) - 32'd1);
        etc = e & ~l & ((u == DIR_UP) ? (mq[k] == mods[k] - 1) : (mq[k] == 0));
        x   = '{cyc, k, 5'(mq[k]), etc, mw[k], 1'b0, "rand"};
        sb.push_back(x);
        if (r) begin
          mq[k] = 0; mw[k] = 1'b0;
        end else if (l) begin
          mq[k] = (dv < mods[k]) ? dv : mods[k] - 1; mw[k] = 1'b0;
        end else if (e && u == DIR_UP) begin
          mw[k] = (mq[k] == mods[k] - 1);
          mq[k] = mw[k] ? 0 : mq[k] + 1;
        end else if (e) begin
          mw[k] = (mq[k] == 0);
          mq[k] = mw[k] ? mods[k] - 1 : mq[k] - 1;
        end else begin
          mw[k] = 1'b0;
        end
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up_dn = DIR_UP; load = 1'b0; din = '0;

    // Ten-state counter: count up through a wrap
    step(0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, "");
    for (int k = 0; k < 13; k++)
      step(0, 0, 1, DIR_UP, 0, 0, 1, 5'(k % 10), (k == 9), (k == 10), 0, "t1_up");

    // Ten-state counter: load 7 then count down through a wrap
    step(0, 0, 0, 0, 1, 7, 1, 3, 0, 0, 0, "t2_load");
    for (int k = 0; k < 9; k++)
      step(0, 0, 1, DIR_DN, 0, 0, 1, 5'((k <= 7) ? 7 - k : 9), (k == 7), (k == 8), 0, "t2_dn");
    step(0, 0, 0, DIR_DN, 0, 0, 1, 8, 0, 0, 0, "t2_end");

    // Ten-state counter: clamped load, then load wins over a simultaneous enable
    step(0, 0, 0, DIR_UP, 1, 13, 1, 8, 0, 0, 0, "t3_ld13");
    step(0, 0, 1, DIR_UP, 1, 4,  1, 9, 0, 0, 0, "t3_clamp");
    step(0, 0, 0, DIR_UP, 0, 0,  1, 4, 0, 0, 0, "t3_ld_no_step");

    // Sixteen-state counter: reset beats load and enable at the terminal count
    step(1, 1, 0, DIR_UP, 0, 0,  0, 0,  0, 0, 0, "");
    step(1, 0, 0, DIR_UP, 1, 15, 1, 0,  0, 0, 0, "t4_rst_q");
    step(1, 0, 0, DIR_UP, 0, 0,  1, 15, 0, 0, 0, "t4_hold15");
    step(1, 1, 1, DIR_UP, 1, 3,  1, 15, 0, 0, 0, "t4_rst_at15");
    step(1, 0, 0, DIR_UP, 0, 0,  1, 0,  0, 0, 0, "t4_after_rst");
    step(1, 0, 0, DIR_UP, 0, 0,  1, 0,  0, 0, 0, "t4_hold0");

    // Sixteen-state counter: hold at 6, then alternate direction every cycle
    step(1, 0, 0, DIR_UP, 1, 6, 1, 0, 0, 0, 0, "t5_load");
    for (int k = 0; k < 5; k++)
      step(1, 0, 0, DIR_UP, 0, 0, 1, 6, 0, 0, 1, "t5_hold");
    step(1, 0, 1, DIR_UP, 0, 0, 1, 6, 0, 0, 0, "t5_up1");
    step(1, 0, 1, DIR_DN, 0, 0, 1, 7, 0, 0, 0, "t5_dn1");
    step(1, 0, 1, DIR_UP, 0, 0, 1, 6, 0, 0, 0, "t5_up2");
    step(1, 0, 1, DIR_DN, 0, 0, 1, 7, 0, 0, 0, "t5_dn2");
    step(1, 0, 0, DIR_UP, 0, 0, 1, 6, 0, 0, 0, "t5_end");

    rand_phase();

    repeat (4) @(negedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations pending, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
